// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency on-chip data RAM behind the dbus.
// Ports: clk, resetn (async low), dreq (valid/addr/size/strobe/data), dresp (addr_ok/data_ok/data).
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WORDS   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned IW       = $clog2(WORDS);
  localparam logic [63:0] SPAN     = 64'(WORDS) << 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  strb_q;
  logic        ok_q;
  logic [63:0] rdata_q;

  logic [63:0] mem [WORDS];

  logic        live;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic [7:0]  acc_strb;
  logic [63:0] acc_off;
  logic        acc_go;
  logic        in_rng;
  logic        wr_en;
  logic [IW-1:0] idx;
  logic [63:0] rd_word;

  // With LATENCY==1 the accepting edge is also the commit edge,
  // so the access must use the live request instead of the latch.
  assign live      = (state_q == IDLE);
  assign acc_addr  = live ? dreq.addr   : addr_q;
  assign acc_wdata = live ? dreq.data   : wdata_q;
  assign acc_strb  = live ? dreq.strobe : strb_q;

  // An invalid request in WAIT is an abort and wins over commit.
  assign acc_go = live
    ? (dreq.valid && (LATENCY == 1))
    : ((state_q == WAIT) && dreq.valid && (cnt_q == 4'd1));

  assign acc_off = acc_addr - BASE;
  assign in_rng  = (acc_addr >= BASE) && (acc_off < SPAN);
  assign idx     = acc_off[IW+2:3];

  assign rd_word = (in_rng && (acc_strb == 8'd0)) ? mem[idx] : '0;
  assign wr_en   = resetn && acc_go && in_rng && (acc_strb != 8'd0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (acc_strb[i]) begin
          mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      ok_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ok_q    <= 1'b0;
          rdata_q <= '0;
          if (dreq.valid) begin
            addr_q  <= dreq.addr;
            wdata_q <= dreq.data;
            strb_q  <= dreq.strobe;
            cnt_q   <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q <= RESP;
              ok_q    <= 1'b1;
              rdata_q <= rd_word;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (!dreq.valid) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd1) begin
            state_q <= RESP;
            ok_q    <= 1'b1;
            rdata_q <= rd_word;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ok_q    <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ok_q    <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign dresp = '{addr_ok: ok_q, data_ok: ok_q, data: rdata_q};

  logic unused_bits;
  assign unused_bits = ^{dreq.size, acc_off[63:IW+3], acc_off[2:0]};

endmodule
